instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 16 +
 rtl/instr_fetch_queue_sync_fifo.sv | 66 ++++++
 rtl/instr_fetch_queue.sv | 120 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU front-end constants: fetch FSM encoding, PC step and reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned PC_INC           = INSTR_BYTES;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with flush; head is read from registered storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none; the caller must never push when full, and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop_vld && (cnt_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_vld) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

    // Empty head reads as zero so stale or never-written storage is not exposed.
    assign head_dat = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: one outstanding memory request feeding a small instruction queue.
// Latency: memory latency + 1 cycle from request accept to out_valid.
// Backpressure: requests stop while the queue (including the reserved slot) is full.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_ready,
    input  logic                      imem_rvalid,
    input  logic [DATA_W-1:0]         imem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]         out_pc,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_M  = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_RESET = RESET_PC & ALIGN_M;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    fetch_state_e      state_q, state_d, rst_state;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              push_vld, pop_vld, flush, full;
    fetch_entry_t      push_dat, head_dat;
    logic [CNT_W-1:0]  fifo_cnt;

    assign full = (fifo_cnt == CNT_W'(DEPTH));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push_vld = 1'b0;
        flush    = rst;
        imem_req = (state_q == ST_IDLE) && !full && !redirect && !rst;
        case (state_q)
            ST_IDLE: begin
                if (imem_req && imem_ready) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(PC_INC);
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push_vld = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A response still owed by memory must be swallowed after a flush.
        if (redirect) begin
            flush    = 1'b1;
            push_vld = 1'b0;
            pc_d     = redirect_pc & ALIGN_M;
            if (state_q != ST_IDLE) begin
                state_d = imem_rvalid ? ST_IDLE : ST_DROP;
            end
        end
        rst_state = ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) ? ST_DROP : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= rst_state;
            pc_q     <= PC_RESET;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign push_dat = '{pc: req_pc_q, instr: imem_rdata};
    assign pop_vld  = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign imem_addr = pc_q;
    assign out_valid = (fifo_cnt != '0);
    assign out_instr = head_dat.instr;
    assign out_pc    = head_dat.pc;
    assign count     = fifo_cnt;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench: cycle table for the basic fetch flow, hand sequences for flush/stall corners.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic        tbl_rvalid = 1'b0;
    logic [31:0] tbl_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        auto_mem = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req, out_valid, imem_req2, out_valid2;
    logic [31:0] imem_addr, out_instr, out_pc, imem_addr2, out_instr2, out_pc2;
    logic [2:0]  count, count2;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int mem_lat = 1;
    int lat_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    assign imem_rvalid = auto_mem ? mem_rvalid : tbl_rvalid;
    assign imem_rdata  = auto_mem ? mem_rdata  : tbl_rdata;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(mem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(mem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_pc(out_pc2), .redirect(redirect), .redirect_pc(redirect_pc), .count(count2)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: answers each accepted request of dut after mem_lat cycles.
    always @(posedge clk) begin
        if (rst || !auto_mem) begin
            pend       <= 1'b0;
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= 1'b0;
            if (pend) begin
                if (lat_cnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= word_of(pend_addr);
                    pend       <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (imem_req && mem_ready) begin
                if (mem_lat == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= word_of(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    lat_cnt   <= mem_lat - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (imem_req && mem_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        tbl_rvalid = 1'b0;
        mem_ready = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        ordy, redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc, einstr;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int hs0;
        //         rst rdy rv  rdata          ordy redir rpc           req addr          ov  pc            instr         cnt
        tbl[0]  = '{1, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_3000, 0, 32'h0,         32'h0,         0};
        tbl[1]  = '{0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_3000, 0, 32'h0,         32'h0,         0};
        tbl[2]  = '{0, 1, 1, 32'h1111_1111,  1, 0, 32'h0,          0, 32'h0000_3004, 0, 32'h0,         32'h0,         0};
        tbl[3]  = '{0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_3004, 1, 32'h0000_3000, 32'h1111_1111, 1};
        tbl[4]  = '{0, 1, 1, 32'h2222_2222,  1, 0, 32'h0,          0, 32'h0000_3008, 0, 32'h0,         32'h0,         0};
        tbl[5]  = '{0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_3008, 1, 32'h0000_3004, 32'h2222_2222, 1};
        tbl[6]  = '{0, 1, 1, 32'h3333_3333,  1, 0, 32'h0,          0, 32'h0000_300C, 0, 32'h0,         32'h0,         0};
        tbl[7]  = '{0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_300C, 1, 32'h0000_3008, 32'h3333_3333, 1};
        tbl[8]  = '{0, 1, 0, 32'h0,          1, 1, 32'h0000_5006,  0, 32'h0000_300C, 1, 32'h0000_3008, 32'h3333_3333, 1};
        tbl[9]  = '{0, 1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_5004, 0, 32'h0,         32'h0,         0};
        tbl[10] = '{0, 0, 1, 32'h4444_4444,  1, 0, 32'h0,          0, 32'h0000_5008, 0, 32'h0,         32'h0,         0};
        tbl[11] = '{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_5008, 1, 32'h0000_5004, 32'h4444_4444, 1};
        tbl[12] = '{0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_5008, 0, 32'h0,         32'h0,         0};

        // Cycle table: reset values, 2-cycle fetch rhythm, redirect withdrawing a stalled request.
        auto_mem = 1'b0;
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; mem_ready = tbl[i].rdy; tbl_rvalid = tbl[i].rv;
            tbl_rdata = tbl[i].rdata; out_ready = tbl[i].ordy;
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d imem_req", i),  64'(imem_req),  64'(tbl[i].ereq));
            chk($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(tbl[i].eaddr));
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            chk($sformatf("v%0d out_pc", i),    64'(out_pc),    64'(tbl[i].epc));
            chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(tbl[i].einstr));
            chk($sformatf("v%0d count", i),     64'(count),     64'(tbl[i].ecnt));
            tick();
        end

        // Stalled memory: address held; then wrap of the second DUT's PC.
        auto_mem = 1'b1; mem_lat = 1;
        do_reset();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d imem_req", i),  64'(imem_req),  64'd1);
            chk($sformatf("stall%0d imem_addr", i), 64'(imem_addr), 64'h0000_3000);
            tick();
        end
        chk("wrap first addr", 64'(imem_addr2), 64'hFFFF_FFFC);
        mem_ready = 1'b1;
        tick(); tick(); #1;
        chk("wrap imem_req",  64'(imem_req2),  64'd1);
        chk("wrap imem_addr", 64'(imem_addr2), 64'h0000_0000);
        chk("wrap out_pc",    64'(out_pc2),    64'hFFFF_FFFC);

        // Queue fills with decode stalled; one pop admits exactly one request.
        auto_mem = 1'b1; mem_lat = 1;
        do_reset();
        mem_ready = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 20 && count !== 3'd4; i++) begin
            tick(); #1;
        end
        chk("full count",  64'(count),    64'd4);
        chk("full req",    64'(imem_req), 64'd0);
        chk("full out_pc", 64'(out_pc),   64'h0000_3000);
        tick(); tick(); #1;
        chk("full hold count", 64'(count),    64'd4);
        chk("full hold req",   64'(imem_req), 64'd0);
        hs0 = hs_cnt;
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        repeat (10) tick();
        #1;
        chk("refill handshakes", 64'(hs_cnt - hs0), 64'd1);
        chk("refill count",      64'(count),        64'd4);
        chk("refill out_pc",     64'(out_pc),       64'h0000_3004);

        // Redirect during a 3-cycle fetch: stale word dropped, refetch from aligned target.
        auto_mem = 1'b1; mem_lat = 3;
        do_reset();
        mem_ready = 1'b1; out_ready = 1'b1;
        #1;
        chk("first req after reset", 64'(imem_req),  64'd1);
        chk("first addr",            64'(imem_addr), 64'h0000_3000);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_4002;
        #1;
        chk("wait req", 64'(imem_req), 64'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("flush count", 64'(count),    64'd0);
        chk("drop req",    64'(imem_req), 64'd0);
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) begin
            tick(); #1;
        end
        chk("redir out_valid", 64'(out_valid), 64'd1);
        chk("redir out_pc",    64'(out_pc),    64'h0000_4000);
        chk("redir out_instr", 64'(out_instr), 64'(word_of(32'h0000_4000)));

        // Redirect coinciding with a response and a pop at count 2.
        auto_mem = 1'b0;
        do_reset();
        tbl_rdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; tbl_rvalid = 1'b1; tick();
        mem_ready = 1'b1; tbl_rvalid = 1'b0; tick();
        mem_ready = 1'b0; tbl_rvalid = 1'b1; tick();
        mem_ready = 1'b1; tbl_rvalid = 1'b0; tick();
        mem_ready = 1'b0; tbl_rvalid = 1'b1; out_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h0000_6000;
        #1;
        chk("pre-flush count", 64'(count),     64'd2);
        chk("pre-flush valid", 64'(out_valid), 64'd1);
        tick();
        tbl_rvalid = 1'b0; out_ready = 1'b0; redirect = 1'b0;
        #1;
        chk("post-flush count", 64'(count),     64'd0);
        chk("post-flush valid", 64'(out_valid), 64'd0);
        chk("post-flush req",   64'(imem_req),  64'd1);
        chk("post-flush addr",  64'(imem_addr), 64'h0000_6000);
        tick(); #1;
        chk("no late push", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
